// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared converter state encoding, glyph constants and digit decoder
package ssd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SHIFT  = 3'b010,
        ST_COMMIT = 3'b100
    } conv_state_e;

    localparam logic [3:0] SHIFT_ITERS = 4'd8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

    function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// rtl/bin2bcd_iter.sv - iterative double-dabble converter with tear-free committed BCD output
module bin2bcd_iter
    import ssd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        busy
);

    conv_state_e state_q, state_d;
    logic [7:0]  conv_src_q, conv_src_d;
    logic [7:0]  sr_q, sr_d;
    logic [11:0] acc_q, acc_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  iter_q, iter_d;
    logic [11:0] acc_adj;

    always_comb begin
        state_d    = state_q;
        conv_src_d = conv_src_q;
        sr_d       = sr_q;
        acc_d      = acc_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        acc_adj    = acc_q;
        for (int i = 0; i < 3; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (bin != conv_src_q) begin
                    conv_src_d = bin;
                    sr_d       = bin;
                    acc_d      = '0;
                    iter_d     = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Display registers load on the edge that enters COMMIT.
                if (iter_q == SHIFT_ITERS) begin
                    bcd_d   = acc_q;
                    state_d = ST_COMMIT;
                end else begin
                    {acc_d, sr_d} = {acc_adj[10:0], sr_q, 1'b0};
                    iter_d        = iter_q + 4'd1;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            conv_src_q <= '0;
            sr_q       <= '0;
            acc_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
        end else begin
            state_q    <= state_d;
            conv_src_q <= conv_src_d;
            sr_q       <= sr_d;
            acc_q      <= acc_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = (state_q == ST_SHIFT) || (state_q == ST_COMMIT);

endmodule

// File: rtl/score_ssd_driver.sv
// rtl/score_ssd_driver.sv - score/level display on a 4-digit active-low seven-segment panel
module score_ssd_driver
    import ssd_pkg::*;
#(
    parameter int DIGIT_CYCLES = 65536,
    parameter int BLINK_BITS   = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] score,
    input  logic [2:0] level,
    input  logic       flash,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       busy
);

    localparam int SCAN_LSB = $clog2(DIGIT_CYCLES);
    localparam int SCAN_W   = SCAN_LSB + 2;

    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    logic [3:0]            an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic [11:0]           bcd;
    logic [1:0]            digit_idx;

    bin2bcd_iter u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (score),
        .bcd   (bcd),
        .busy  (busy)
    );

    always_comb begin
        scan_d    = scan_q + 1'b1;
        blink_d   = blink_q + 1'b1;
        digit_idx = scan_q[SCAN_W-1 -: 2];
        an_d      = 4'b1111;
        seg_d     = SEG_BLANK;
        if (!(flash && blink_q[BLINK_BITS-1])) begin
            an_d = ~(4'b0001 << digit_idx);
            // Leading zeros are suppressed; the units digit is always lit.
            case (digit_idx)
                2'd0:    seg_d = digit_to_seg(bcd[3:0]);
                2'd1:    seg_d = (bcd[11:4] == 8'd0) ? SEG_BLANK : digit_to_seg(bcd[7:4]);
                2'd2:    seg_d = (bcd[11:8] == 4'd0) ? SEG_BLANK : digit_to_seg(bcd[11:8]);
                default: seg_d = digit_to_seg({1'b0, level});
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q  <= '0;
            blink_q <= '0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
        end else begin
            scan_q  <= scan_d;
            blink_q <= blink_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
